// File: rtl/sort_checker_if.sv
// Handshake, memory and result bundle shared by sort_checker and its host.
// Signals: enable/length in, ready out; address/wren/rdata memory; results.
interface sort_checker_if #(
   parameter int SUM_W = 16
);
   logic             enable;
   logic             ready;
   logic [9:0]       length;
   logic [7:0]       rdata;
   logic [7:0]       address;
   logic             wren;
   logic             sorted;
   logic [7:0]       bad_idx;
   logic [7:0]       min_val;
   logic [7:0]       max_val;
   logic [SUM_W-1:0] checksum;

   modport master (
      input  enable, length, rdata,
      output ready, address, wren,
      output sorted, bad_idx, min_val, max_val, checksum
   );

   modport slave (
      output enable, length, rdata,
      input  ready, address, wren,
      input  sorted, bad_idx, min_val, max_val, checksum
   );
endinterface

// File: rtl/sort_checker.sv
// Post-sort memory scanner: checks mem[0..n-1] is non-decreasing and
// reports first bad index, min, max and a wrapping checksum.
// Ports: clk, rst_n (async active-low), bus (sort_checker_if.master).
// Optional macro SORT_CHECK_EARLY_EXIT_EN stops at the first violation.
module sort_checker #(
   parameter int RD_LAT = 1,
   parameter int SUM_W  = 16
) (
   input logic           clk,
   input logic           rst_n,
   sort_checker_if.master bus
);
   typedef enum logic [1:0] {
      IDLE, ISSUE, DRAIN, FINISH
   } state_t;

   state_t           state_q, state_d;
   logic [8:0]       n_q, n_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [1:0]       dcnt_q, dcnt_d;
   logic             v_q, v_d;
   logic             ready_q, ready_d;
   logic             sorted_q, sorted_d;
   logic [7:0]       bad_q, bad_d;
   logic [7:0]       min_q, min_d;
   logic [7:0]       max_q, max_d;
   logic [7:0]       prev_q, prev_d;
   logic [SUM_W-1:0] sum_q, sum_d;

   logic [8:0] len_c;
   logic       smp;
   logic       viol;
   logic       early;

   assign len_c = (bus.length > 10'd256) ? 9'd256
                                         : bus.length[8:0];

`ifdef SORT_CHECK_EARLY_EXIT_EN
   assign early = 1'b1;
`else
   assign early = 1'b0;
`endif

   // Sample strobe: address issued RD_LAT edges ago, and only while
   // the scan is live, so in-flight reads die on an early stop.
   assign smp = ((RD_LAT == 1) ? (state_q == ISSUE) : v_q)
              && (state_q == ISSUE || state_q == DRAIN);

   assign viol = smp && (cnt_q != 8'd0)
              && (bus.rdata < prev_q) && sorted_q;

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      dcnt_d   = dcnt_q;
      v_d      = (state_q == ISSUE);
      ready_d  = ready_q;
      sorted_d = sorted_q;
      bad_d    = bad_q;
      min_d    = min_q;
      max_d    = max_q;
      prev_d   = prev_q;
      sum_d    = sum_q;

      if (smp) begin
         if (bus.rdata < min_q) min_d = bus.rdata;
         if (bus.rdata > max_q) max_d = bus.rdata;
         sum_d  = sum_q + SUM_W'(bus.rdata);
         prev_d = bus.rdata;
         cnt_d  = cnt_q + 8'd1;
         if (viol) begin
            sorted_d = 1'b0;
            bad_d    = cnt_q;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (bus.enable) begin
               n_d      = len_c;
               addr_d   = 8'd0;
               cnt_d    = 8'd0;
               ready_d  = 1'b0;
               sorted_d = 1'b1;
               bad_d    = 8'd0;
               min_d    = 8'hFF;
               max_d    = 8'h00;
               sum_d    = '0;
               state_d  = (len_c == 9'd0) ? FINISH : ISSUE;
            end
         end
         ISSUE: begin
            if (early && viol) begin
               state_d = FINISH;
            end else if ({1'b0, addr_q} == n_q - 9'd1) begin
               dcnt_d  = 2'd0;
               state_d = DRAIN;
            end else begin
               addr_d = addr_q + 8'd1;
            end
         end
         DRAIN: begin
            if (early && viol) begin
               state_d = FINISH;
            end else if (dcnt_q == 2'(RD_LAT - 1)) begin
               state_d = FINISH;
            end else begin
               dcnt_d = dcnt_q + 2'd1;
            end
         end
         FINISH: begin
            ready_d = 1'b1;
            addr_d  = 8'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         n_q      <= 9'd0;
         addr_q   <= 8'd0;
         cnt_q    <= 8'd0;
         dcnt_q   <= 2'd0;
         v_q      <= 1'b0;
         ready_q  <= 1'b1;
         sorted_q <= 1'b1;
         bad_q    <= 8'd0;
         min_q    <= 8'hFF;
         max_q    <= 8'h00;
         prev_q   <= 8'd0;
         sum_q    <= '0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         dcnt_q   <= dcnt_d;
         v_q      <= v_d;
         ready_q  <= ready_d;
         sorted_q <= sorted_d;
         bad_q    <= bad_d;
         min_q    <= min_d;
         max_q    <= max_d;
         prev_q   <= prev_d;
         sum_q    <= sum_d;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.address  = addr_q;
   assign bus.wren     = 1'b0;
   assign bus.sorted   = sorted_q;
   assign bus.bad_idx  = bad_q;
   assign bus.min_val  = min_q;
   assign bus.max_val  = max_q;
   assign bus.checksum = sum_q;
endmodule

// File: doc/sort_checker.md
Name: sort_checker

Overview:
- Post-sort memory reader. Shares the enable/ready handshake and 256x8 single-port memory interface with the bubble-sort engine.
- After the sorter finishes, the top-level FSM hands memory ownership to this block. It scans mem[0..len-1] and reports whether the data is non-decreasing.
- Also reports the first violating index, min, max and a 16-bit checksum, for on-board self-check and HEX display.

Parameters:
- RD_LAT, 1, memory read latency in cycles from address presented to rdata valid; legal values 1 or 2.
- SUM_W, 16, checksum width in bits; the sum wraps modulo 2^SUM_W.

Ports:
- clk  input  1  system clock (CLOCK_50 at top).
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  start request; sampled only while ready=1.
- ready  output  1  1 = idle or finished, results valid; 0 = scan in progress.
- length  input  10  number of elements to check; latched at start.
- rdata  input  8  memory read data.
- address  output  8  memory address.
- wren  output  1  memory write enable; constant 0, so the port drops into the shared memory mux.
- sorted  output  1  1 = scanned data is non-decreasing.
- bad_idx  output  8  index i of the first element with mem[i] < mem[i-1]; 0 when sorted=1.
- min_val  output  8  smallest element scanned.
- max_val  output  8  largest element scanned.
- checksum  output  SUM_W  sum of scanned elements modulo 2^SUM_W.

Behaviour:
- Reset (async, any state):
  - State IDLE.
  - ready=1, address=0, wren=0, sorted=1, bad_idx=0.
  - min_val=8'hFF, max_val=8'h00, checksum=0.
- Length rules:
  - Latched length is clamped to 256 when length > 256.
  - length = 0 is legal.
- States:
  - IDLE:
    - ready=1; address held at 0.
    - On enable=1 at a clock edge: latch the clamped length as n.
    - At that same edge: clear sorted=1, bad_idx=0, min=FF, max=00, checksum=0; drop ready.
    - Go to ISSUE, or to FINISH if n=0.
  - ISSUE:
    - address counts 0,1,...,n-1, one per cycle, starting the cycle after acceptance.
    - After the edge that presents address n-1, go to DRAIN.
  - DRAIN: wait RD_LAT cycles until the last element is sampled, then go to FINISH.
  - FINISH: ready<=1; return to IDLE; results held until the next accepted enable.
- Data path:
  - The element for address k is sampled RD_LAT edges after address k is first driven.
  - Per sample: min/max update; checksum += zero-extended element.
  - For k ≥ 1, compare with the previous sample. If it is smaller and sorted=1: sorted<=0, bad_idx<=k. Later violations do not change bad_idx.
- Latency:
  - n ≥ 1: ready reasserts at edge n+RD_LAT+1 after the acceptance edge.
  - n = 0: ready reasserts at edge 1; results are the cleared values.
- Boundary conditions:
  - enable while ready=0 is ignored; enable held high after FINISH starts a new scan (level-sensitive in IDLE).
  - A length change during a scan has no effect.
  - Address never exceeds n-1 and never wraps; n=256 ends at address 255.
  - Reset mid-scan aborts immediately to the reset values; no partial results are kept.

Optional Feature:
- Macro: SORT_CHECK_EARLY_EXIT_EN.
- Defined:
  - On the first violation, stop issuing new addresses and drop any in-flight samples.
  - Go directly to FINISH; ready reasserts at the edge after the violating sample.
  - min/max/checksum cover only elements 0..bad_idx.
- Undefined: always scans all n elements, as specified above.

Test Plan:
- mem=[3,7,7,9], length=4, RD_LAT=1, enable pulse:
  - sorted=1, bad_idx=0, min=3, max=9, checksum=26.
  - ready low for exactly 5 cycles; high again at edge 6.
- mem=[5,2,8,1], length=4, without EARLY_EXIT:
  - sorted=0, bad_idx=1, min=1, max=8, checksum=16.
- Same data with SORT_CHECK_EARLY_EXIT_EN:
  - sorted=0, bad_idx=1, min=2, max=5, checksum=7.
  - ready reasserts before edge 6; address never reaches 2 after the stop.
- length=0:
  - ready high again at edge 1; sorted=1, min=FF, max=00, checksum=0.
  - No address other than 0 is driven.
- length=300 with mem[i]=i for 0..255:
  - Clamped to 256; sorted=1, min=0, max=255, checksum=32640.
  - Last address 255.
- Reset and handshake:
  - rst_n low at scan cycle 3 with length=10: all outputs return to reset values asynchronously.
  - After release, enable with ready=1 restarts the scan.
  - enable pulsed while ready=0 produces no restart.
